// File: rtl/mem_responder_if.sv
// Request/response bundle between a load/store initiator and mem_responder.
// Handshake: the master raises req with we/byte_en/addr/wdata stable and holds it until it sees ack;
// the slave answers with a one-cycle ack, with rdata and err meaningful only while ack is high.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic        byte_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, we, byte_en, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, byte_en, addr, wdata,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Wait-state data memory: latches one load/store, waits WAIT_CYCLES, performs it on a
// 2^ADDR_W x 32 RAM and acknowledges with a one-cycle ack pulse.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  mem_responder_if.slave  bus,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic                r_byte;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_lane;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_start;
  logic                w_misaligned;
  logic [31:0]         w_rd_word;
  logic [7:0]          w_rd_byte;
  logic                w_unused_addr;

  assign w_start       = (r_state == S_IDLE) && bus.req;
  assign w_misaligned  = !r_byte && (r_lane != 2'd0);
  assign w_rd_word     = r_mem[r_idx];
  assign w_rd_byte     = w_rd_word[{r_lane, 3'b000} +: 8];
  // Upper address bits are dropped on purpose so accesses wrap modulo the RAM size.
  assign w_unused_addr = ^bus.addr[31:ADDR_W+2];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.req) w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt   <= 4'(WAIT_CYCLES);
        r_we    <= bus.we;
        r_byte  <= bus.byte_en;
        r_idx   <= bus.addr[ADDR_W+1:2];
        r_lane  <= bus.addr[1:0];
        r_wdata <= bus.wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        r_err <= w_misaligned;
        if (!w_misaligned && !r_we)
          r_rdata <= r_byte ? {24'd0, w_rd_byte} : w_rd_word;
      end
    end
  end

  // RAM has no reset; Reset only blocks a write that would commit at the same edge.
  always_ff @(posedge Clk) begin
    if (!Reset && (r_state == S_ACCESS) && r_we && !w_misaligned) begin
      if (r_byte)
        r_mem[r_idx][{r_lane, 3'b000} +: 8] <= r_wdata[7:0];
      else
        r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.ack     = (r_state == S_DONE);
  assign bus.err     = r_err && (r_state == S_DONE);
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.rdata   = r_rdata;
  assign o_dbg_state = r_state;

endmodule
